serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 124 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl -- bit-serial adder controller.
//
// One full-adder cell is time-shared across the N bits of an addition. The
// cell handles one bit per clock, LSB first, and the carry is held in a flop
// between cycles. A new request is accepted only in IDLE. The result appears
// on z/ripout together with a one-cycle done pulse.
//
// Optional build macro: SERIAL_SUB_EN adds a 'sub' input that selects x - y.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   synchronous active-low reset
//   start   in   request a new operation (sampled only in IDLE)
//   x, y    in   N-bit operands, captured on an accepted start
//   ripin   in   carry-in, captured on an accepted start
//   sub     in   (SERIAL_SUB_EN only) 1 = subtract: z = x - y
//   busy    out  high while bits are being processed
//   done    out  one-cycle pulse, z/ripout valid
//   z       out  N-bit sum (registered, holds the last result)
//   ripout  out  final carry-out (registered)
module serial_add_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         ripin,
`ifdef SERIAL_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [N-1:0] z,
  output logic         ripout
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic [N-1:0]  z_sh;
  logic          carry;
  logic [CW-1:0] cnt;

  logic          fa_s;
  logic          fa_c;
  logic [N-1:0]  b_load;
  logic          c_load;

  // The single shared full-adder cell
  always_comb begin
    fa_s = a_sr[0] ^ b_sr[0] ^ carry;
    fa_c = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  end

  // Operand B and the initial carry as loaded on start. Subtraction is
  // x + ~y + 1, so the carry-in is forced to 1 and ripin is ignored.
  always_comb begin
    b_load = y;
    c_load = ripin;
`ifdef SERIAL_SUB_EN
    if (sub) begin
      b_load = ~y;
      c_load = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      z_sh   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      z      <= '0;
      ripout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= x;
            b_sr  <= b_load;
            carry <= c_load;
            cnt   <= '0;
            z_sh  <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          z_sh  <= {fa_s, z_sh[N-1:1]};
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= fa_c;
          cnt   <= cnt + 1'b1;
          // The last bit is processed on this edge, so the full result is
          // the final shift of the shadow register, not z_sh itself.
          if (cnt == CW'(N - 1)) begin
            z      <= {fa_s, z_sh[N-1:1]};
            ripout <= fa_c;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (N=8). Directed table vectors,
// randomized operations against an arithmetic reference model, plus
// hand-written sequences for reset, held start and mid-operation reset.
module tb_serial_add_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         ripin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [N-1:0] z;
  logic         ripout;

  int vectors = 0;
  int miscompares = 0;

  // Last result the bench expects z/ripout to be holding.
  longint unsigned hold_z = 0;
  longint unsigned hold_c = 0;

  serial_add_ctrl #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .x      (x),
    .y      (y),
    .ripin  (ripin),
`ifdef SERIAL_SUB_EN
    .sub    (sub),
`endif
    .busy   (busy),
    .done   (done),
    .z      (z),
    .ripout (ripout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] vx;
    logic [7:0] vy;
    logic       vrin;
    logic       vsub;
    logic [7:0] ez;
    logic       ec;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint unsigned act,
                     input longint unsigned exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: {ripout,z} = x + y + cin in plain (N+1)-bit arithmetic.
  function automatic longint unsigned model(input longint unsigned ax,
                                            input longint unsigned ay,
                                            input bit rin, input bit s);
    longint unsigned mask = (64'd1 << N) - 1;
    if (s) return (ax + ((~ay) & mask) + 1) & ((mask << 1) | 1);
    return (ax + ay + rin) & ((mask << 1) | 1);
  endfunction

  // One full operation from IDLE, checking cycle-accurate busy/done, that
  // z/ripout hold during RUN, and the final result. Operands are scrambled
  // during RUN to show they have no effect.
  task automatic run_op(input logic [N-1:0] ax, input logic [N-1:0] ay,
                        input logic rin, input logic s,
                        input longint unsigned ez, input longint unsigned ec);
    x = ax; y = ay; ripin = rin; sub = s; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("busy_run", busy, 1);
      chk("done_run", done, 0);
      chk("z_hold_run", z, hold_z);
      x = N'($urandom); y = N'($urandom); ripin = 1'($urandom);
      sub = 1'($urandom);
      tick();
    end
    chk("done_pulse", done, 1);
    chk("busy_at_done", busy, 0);
    chk("z_result", z, ez);
    chk("ripout_result", ripout, ec);
    hold_z = ez; hold_c = ec;
    sub = 1'b0;
    tick();
    chk("done_cleared", done, 0);
    chk("busy_after", busy, 0);
    chk("z_held_after", z, hold_z);
  endtask

  vec_t tbl[$];

  initial begin
    longint unsigned r;
    logic [N-1:0] rx, ry;
    logic rr;

    tbl.push_back('{8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0});
    tbl.push_back('{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1});
    tbl.push_back('{8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1});
    tbl.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
    tbl.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
    tbl.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0});
    tbl.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0});
`ifdef SERIAL_SUB_EN
    tbl.push_back('{8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1});
    tbl.push_back('{8'h01, 8'h02, 1'b0, 1'b1, 8'hFF, 1'b0});
    tbl.push_back('{8'h55, 8'h55, 1'b0, 1'b1, 8'h00, 1'b1});
`endif

    rst_n = 1'b0; start = 1'b0; x = '0; y = '0; ripin = 1'b0; sub = 1'b0;

    // Reset held 3 cycles, then idle for 10 cycles with start low.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      x = N'($urandom); y = N'($urandom);
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_z", z, 0);
      chk("idle_ripout", ripout, 0);
    end

    // Directed table.
    foreach (tbl[i])
      run_op(tbl[i].vx, tbl[i].vy, tbl[i].vrin, tbl[i].vsub,
             tbl[i].ez, tbl[i].ec);

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      logic s;
      rx = N'($urandom); ry = N'($urandom); rr = 1'($urandom);
`ifdef SERIAL_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      r = model(rx, ry, rr, s);
      run_op(rx, ry, rr, s, r & ((64'd1 << N) - 1), r >> N);
    end

    // start held high: one accept every N+2 edges, operands sampled only
    // at the accepting edge.
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rx = N'($urandom); ry = N'($urandom); rr = 1'($urandom);
      x = rx; y = ry; ripin = rr;
      r = model(rx, ry, rr, 1'b0);
      tick();
      for (int i = 0; i < N; i++) begin
        chk("held_busy", busy, 1);
        chk("held_done", done, 0);
        x = N'($urandom); y = N'($urandom); ripin = 1'($urandom);
        tick();
      end
      chk("held_done_pulse", done, 1);
      chk("held_z", z, r & ((64'd1 << N) - 1));
      chk("held_ripout", ripout, r >> N);
      hold_z = r & ((64'd1 << N) - 1); hold_c = r >> N;
      x = N'($urandom); y = N'($urandom);
      tick();
      chk("held_gap_busy", busy, 0);
      chk("held_gap_done", done, 0);
    end
    start = 1'b0;
    tick();
    chk("held_end_idle", busy, 0);

    // Reset at the 4th RUN edge aborts with no done pulse.
    x = 8'hAA; y = 8'h55; ripin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_z", z, 0);
    chk("midrst_ripout", ripout, 0);
    hold_z = 0; hold_c = 0;
    for (int i = 0; i < N + 3; i++) begin
      tick();
      chk("midrst_no_done", done, 0);
      chk("midrst_no_busy", busy, 0);
    end
    run_op(8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Invariant checked every cycle, away from the active edge.
  always @(negedge clk)
    if (busy && done) begin
      miscompares++;
      $display("FAIL busy_done_both: busy=%0b done=%0b required not both 1",
               busy, done);
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
